// File: rtl/ysyx_25040109_ifu.sv
// Single-issue instruction fetch unit: request, wait for memory, hold for decode, wait for commit.
// Optional misaligned-PC fault detection is enabled by defining YSYX_25040109_IFU_ALIGN_CHK_EN.
module ysyx_25040109_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        in_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        inst_fault,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    EXEC  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        fault_q;
  logic        misaligned;

`ifdef YSYX_25040109_IFU_ALIGN_CHK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ: begin
        if (misaligned) begin
          state_nxt = VALID;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) state_nxt = WAIT;
        end
      end
      WAIT:  if (imem_resp_valid) state_nxt = VALID;
      VALID: begin
        out_valid = 1'b1;
        if (in_ready) state_nxt = EXEC;
      end
      EXEC:  if (commit_valid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Faulting fetches deliver a zero instruction word so decode never sees stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (misaligned) begin
            inst_q  <= 32'h0000_0000;
            fault_q <= 1'b1;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            inst_q  <= imem_resp_err ? 32'h0000_0000 : imem_rdata;
            fault_q <= imem_resp_err;
          end
        end
        EXEC: begin
          if (commit_valid) pc_q <= commit_pc;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_fault = fault_q;

endmodule

// File: tb/tb_ysyx_25040109_ifu.sv
// Self-checking bench for ysyx_25040109_ifu: the bench plays memory, decoder and committer
// and checks each instruction transaction against its own expected PC / instruction / fault.
module tb_ysyx_25040109_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp_err = 1'b0;
  logic        out_valid;
  logic        in_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_fault;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_pc = 32'h0;

  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  logic [31:0] exp_pc;

  ysyx_25040109_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_rdata     (imem_rdata),
    .imem_resp_err  (imem_resp_err),
    .out_valid      (out_valid),
    .in_ready       (in_ready),
    .inst           (inst),
    .pc             (pc),
    .inst_fault     (inst_fault),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_addr"}, imem_addr, RESET_PC);
    chk({tag, "_pc"}, pc, RESET_PC);
    chk({tag, "_inst"}, inst, 0);
    chk({tag, "_fault"}, inst_fault, 0);
  endtask

  // One full instruction transaction, entered with the DUT expected in its request phase.
  task automatic fetch(input int rdy_dly, input int rsp_dly, input logic [31:0] data,
                       input logic err, input int acc_dly, input int cmt_dly,
                       input logic [31:0] nxt);
    logic [31:0] exp_inst;
    logic        exp_fault;
    logic        mis;
    mis = 1'b0;
`ifdef YSYX_25040109_IFU_ALIGN_CHK_EN
    mis = (exp_pc[1:0] != 2'b00);
`endif
    chk("req_out_valid", out_valid, 0);
    chk("req_addr", imem_addr, exp_pc);
    if (mis) begin
      chk("misalign_no_req", imem_req_valid, 0);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      exp_inst  = 32'h0;
      exp_fault = 1'b1;
    end else begin
      chk("req_valid", imem_req_valid, 1);
      for (int i = 0; i < rdy_dly; i++) begin
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'($urandom_range(0, 1));
        imem_rdata      = $urandom;
        tick();
        chk("req_hold_valid", imem_req_valid, 1);
        chk("req_hold_addr", imem_addr, exp_pc);
        chk("req_hold_out_valid", out_valid, 0);
      end
      imem_resp_valid = 1'b0;
      imem_req_ready  = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      chk("wait_req_valid", imem_req_valid, 0);
      for (int i = 0; i < rsp_dly; i++) begin
        in_ready = 1'($urandom_range(0, 1));
        tick();
        chk("wait_out_valid", out_valid, 0);
        chk("wait_req_valid2", imem_req_valid, 0);
      end
      in_ready        = 1'b0;
      imem_resp_valid = 1'b1;
      imem_rdata      = data;
      imem_resp_err   = err;
      tick();
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      imem_rdata      = $urandom;
      exp_inst  = err ? 32'h0 : data;
      exp_fault = err;
    end
    chk("valid_out_valid", out_valid, 1);
    chk("valid_inst", inst, exp_inst);
    chk("valid_fault", inst_fault, exp_fault);
    chk("valid_pc", pc, exp_pc);
    for (int i = 0; i < acc_dly; i++) begin
      in_ready        = 1'b0;
      imem_resp_valid = 1'($urandom_range(0, 1));
      imem_resp_err   = 1'($urandom_range(0, 1));
      imem_rdata      = $urandom;
      commit_valid    = 1'($urandom_range(0, 1));
      commit_pc       = $urandom;
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_inst", inst, exp_inst);
      chk("hold_fault", inst_fault, exp_fault);
      chk("hold_pc", pc, exp_pc);
      chk("hold_no_req", imem_req_valid, 0);
    end
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    commit_valid    = 1'b0;
    in_ready        = 1'b1;
    tick();
    in_ready = 1'b0;
    chk("exec_out_valid", out_valid, 0);
    chk("exec_req_valid", imem_req_valid, 0);
    for (int i = 0; i < cmt_dly; i++) begin
      in_ready = 1'($urandom_range(0, 1));
      tick();
      chk("exec_wait_out_valid", out_valid, 0);
      chk("exec_wait_req_valid", imem_req_valid, 0);
      chk("exec_wait_pc", pc, exp_pc);
    end
    in_ready     = 1'b0;
    commit_valid = 1'b1;
    commit_pc    = nxt;
    tick();
    commit_valid = 1'b0;
    commit_pc    = $urandom;
    exp_pc       = nxt;
  endtask

  initial begin
    logic [31:0] r;
    tick();
    tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    #1;
    chk("idle_no_req", imem_req_valid, 0);
    tick();
    exp_pc = RESET_PC;

    fetch(0, 0, 32'h0000_0413, 1'b0, 0, 0, 32'h8000_0004);
    fetch(3, 1, $urandom, 1'b0, 0, 1, 32'h8000_0008);
    fetch(0, 2, $urandom, 1'b0, 4, 0, 32'h8000_0100);
    fetch(0, 0, 32'hDEAD_BEEF, 1'b1, 1, 0, 32'h8000_0102);
    fetch(1, 0, $urandom, 1'b0, 0, 0, 32'hFFFF_FFFC);
    fetch(0, 1, $urandom, 1'b0, 0, 0, 32'h0000_0000);

    for (int n = 0; n < 40; n++) begin
      r = $urandom;
      if ($urandom_range(0, 5) != 0) r[1:0] = 2'b00;
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            1'($urandom_range(0, 3) == 0), $urandom_range(0, 3),
            $urandom_range(0, 2), r);
    end

    // Abort a fetch in flight, then present a stale response across reset release.
    exp_pc = 32'h8000_0000;
    rst_n  = 1'b0;
    #1;
    chk_reset_outputs("rst2");
    rst_n = 1'b1;
    tick();
    if (imem_req_valid === 1'b1) begin
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h1234_5678;
    tick();
    rst_n = 1'b1;
    tick();
    chk("stale_req_valid", imem_req_valid, 1);
    chk("stale_out_valid", out_valid, 0);
    chk("stale_inst", inst, 0);
    tick();
    chk("stale_req_valid2", imem_req_valid, 1);
    chk("stale_out_valid2", out_valid, 0);
    imem_resp_valid = 1'b0;
    exp_pc = RESET_PC;
    fetch(0, 0, 32'h0000_0013, 1'b0, 0, 0, 32'h8000_0004);
    chk("final_addr", imem_addr, 32'h8000_0004);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
